// File: rtl/sm_frame_rx.sv
// sm_frame_rx: collects A, B and CRC beats from a valid/ready stream and presents the checked A/B pair.
// Build option: define SM_FRAME_RX_DROP_BAD_EN to drop frames whose CRC does not match instead of presenting them.
module sm_frame_rx #(
  parameter int                DATA_W   = 16,
  parameter logic [DATA_W-1:0] CRC_POLY = 16'h1021,
  parameter logic [DATA_W-1:0] CRC_INIT = 16'hFFFF,
  parameter int                TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_a,
  output logic [DATA_W-1:0] m_b,
  output logic              m_crc_ok,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              abort,
  output logic [7:0]        crc_err_cnt
);

  localparam int               CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_V  = CNT_W'(TIMEOUT);
  localparam logic             TIMEOUT_EN = (TIMEOUT != 0);

`ifdef SM_FRAME_RX_DROP_BAD_EN
  localparam logic DROP_BAD = 1'b1;
`else
  localparam logic DROP_BAD = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GOT_A = 2'd1,
    S_GOT_B = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  // Full-word CRC update, MSB first, non-reflected.
  function automatic logic [DATA_W-1:0] crc_step(input logic [DATA_W-1:0] crc_in,
                                                 input logic [DATA_W-1:0] data);
    logic [DATA_W-1:0] c;
    logic              fb;
    c = crc_in;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb = c[DATA_W-1] ^ data[i];
      c  = {c[DATA_W-2:0], 1'b0} ^ (fb ? CRC_POLY : {DATA_W{1'b0}});
    end
    return c;
  endfunction

  state_t            state_r;
  logic [DATA_W-1:0] a_r;
  logic [DATA_W-1:0] b_r;
  logic [DATA_W-1:0] crc_r;
  logic [CNT_W-1:0]  to_cnt_r;

  logic              accept_s;
  logic              crc_match_s;
  logic              timeout_s;
  logic              present_s;
  logic              go_out_s;
  logic [DATA_W-1:0] crc_base_s;
  logic [DATA_W-1:0] crc_next_s;

  // Beat acceptance, CRC datapath, timeout detection and next-cycle OUT prediction.
  always_comb begin
    accept_s    = s_valid & s_ready;
    crc_match_s = (s_data == crc_r);

    if (state_r == S_IDLE) begin
      crc_base_s = CRC_INIT;
    end else begin
      crc_base_s = crc_r;
    end
    crc_next_s = crc_step(crc_base_s, s_data);

    // An accept on the same edge always beats the timeout.
    if (TIMEOUT_EN && !accept_s && ((state_r == S_GOT_A) || (state_r == S_GOT_B))) begin
      timeout_s = ((to_cnt_r + 1'b1) == TIMEOUT_V);
    end else begin
      timeout_s = 1'b0;
    end

    if (DROP_BAD) begin
      present_s = crc_match_s;
    end else begin
      present_s = 1'b1;
    end

    case (state_r)
      S_GOT_B: go_out_s = accept_s & present_s;
      S_OUT:   go_out_s = ~m_ready;
      default: go_out_s = 1'b0;
    endcase
  end

  // Frame FSM with all outputs registered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= S_IDLE;
      a_r         <= '0;
      b_r         <= '0;
      crc_r       <= '0;
      to_cnt_r    <= '0;
      s_ready     <= 1'b0;
      m_a         <= '0;
      m_b         <= '0;
      m_crc_ok    <= 1'b0;
      m_valid     <= 1'b0;
      abort       <= 1'b0;
      crc_err_cnt <= 8'd0;
    end else begin
      abort   <= 1'b0;
      s_ready <= ~go_out_s;
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            a_r      <= s_data;
            crc_r    <= crc_next_s;
            to_cnt_r <= '0;
            state_r  <= S_GOT_A;
          end
        end
        S_GOT_A: begin
          if (accept_s) begin
            b_r      <= s_data;
            crc_r    <= crc_next_s;
            to_cnt_r <= '0;
            state_r  <= S_GOT_B;
          end else if (timeout_s) begin
            to_cnt_r <= '0;
            abort    <= 1'b1;
            state_r  <= S_IDLE;
          end else begin
            to_cnt_r <= to_cnt_r + 1'b1;
          end
        end
        S_GOT_B: begin
          if (accept_s) begin
            to_cnt_r <= '0;
            if (!crc_match_s && (crc_err_cnt != 8'hFF)) begin
              crc_err_cnt <= crc_err_cnt + 8'd1;
            end
            if (present_s) begin
              m_a      <= a_r;
              m_b      <= b_r;
              m_crc_ok <= crc_match_s;
              m_valid  <= 1'b1;
              state_r  <= S_OUT;
            end else begin
              state_r  <= S_IDLE;
            end
          end else if (timeout_s) begin
            to_cnt_r <= '0;
            abort    <= 1'b1;
            state_r  <= S_IDLE;
          end else begin
            to_cnt_r <= to_cnt_r + 1'b1;
          end
        end
        S_OUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            state_r <= S_IDLE;
          end
        end
        default: begin
          m_valid <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sm_frame_rx.sv
// tb_sm_frame_rx: randomized and directed checks of sm_frame_rx against a frame-level reference model.
// Expected CRCs come from polynomial long division over the 32-bit A:B message.
module tb_sm_frame_rx;

  localparam logic [15:0] POLY = 16'h1021;
  localparam logic [15:0] INIT = 16'hFFFF;
  localparam int          TO   = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] s_data = 16'h0000;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] m_a;
  logic [15:0] m_b;
  logic        m_crc_ok;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        abort;
  logic [7:0]  crc_err_cnt;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ok;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   err_model = 0;
  int   abort_seen = 0;
  int   abort_exp = 0;
  logic rnd_ready = 1'b0;
  logic ready_val = 1'b1;
  logic drop_bad;

  sm_frame_rx #(
    .DATA_W  (16),
    .CRC_POLY(POLY),
    .CRC_INIT(INIT),
    .TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .m_a        (m_a),
    .m_b        (m_b),
    .m_crc_ok   (m_crc_ok),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .abort      (abort),
    .crc_err_cnt(crc_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Remainder of ((A:B) * x^16 + INIT * x^32) divided by x^16 + POLY.
  function automatic logic [15:0] ref_crc(input logic [15:0] a, input logic [15:0] b);
    logic [47:0] v;
    v = {a, b, 16'h0000} ^ {INIT, 32'h0000_0000};
    for (int i = 47; i >= 16; i--) begin
      if (v[i]) v[i -: 17] = v[i -: 17] ^ {1'b1, POLY};
    end
    return v[15:0];
  endfunction

  // Consumer ready: random or fixed, changed 2 time units after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rnd_ready) m_ready = 1'($urandom_range(0, 1));
      else           m_ready = ready_val;
    end
  end

  // Output monitor: every handshake must match the oldest expected frame.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (abort) abort_seen++;
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_frame", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            check("m_a", 32'(m_a), 32'(e.a));
            check("m_b", 32'(m_b), 32'(e.b));
            check("m_crc_ok", 32'(m_crc_ok), 32'(e.ok));
          end
        end
      end
    end
  end

  // Called at posedge+1; waits gap idle edges, then presents d until accepted.
  task automatic send_beat(input logic [15:0] d, input int gap);
    int wait_n;
    wait_n = 0;
    for (int i = 0; i < gap; i++) begin
      @(posedge clk);
      #1;
    end
    s_valid = 1'b1;
    s_data  = d;
    while (!s_ready && wait_n < 50) begin
      @(posedge clk);
      #1;
      wait_n++;
    end
    if (!s_ready) begin
      check("s_ready_wait", 32'(s_ready), 32'd1);
    end else begin
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] a, input logic [15:0] b, input logic bad,
                            input int g1, input int g2, input int g3);
    logic [15:0] c;
    exp_t        e;
    c = ref_crc(a, b) ^ (bad ? 16'h0001 : 16'h0000);
    send_beat(a, g1);
    send_beat(b, g2);
    send_beat(c, g3);
    if (bad && err_model < 255) err_model++;
    if (!(bad && drop_bad)) begin
      e.a  = a;
      e.b  = b;
      e.ok = ~bad;
      exp_q.push_back(e);
    end
    check("crc_err_cnt", 32'(crc_err_cnt), 32'(err_model));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    check({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    check({tag, "_m_a"}, 32'(m_a), 32'd0);
    check({tag, "_m_b"}, 32'(m_b), 32'd0);
    check({tag, "_m_crc_ok"}, 32'(m_crc_ok), 32'd0);
    check({tag, "_abort"}, 32'(abort), 32'd0);
    check({tag, "_crc_err_cnt"}, 32'(crc_err_cnt), 32'd0);
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    int          drain;
`ifdef SM_FRAME_RX_DROP_BAD_EN
    drop_bad = 1'b1;
`else
    drop_bad = 1'b0;
`endif

    // Reset state and first ready edge.
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rstn = 1'b1;
    check("s_ready_before_edge", 32'(s_ready), 32'd0);
    @(posedge clk);
    #1;
    check("s_ready_after_edge", 32'(s_ready), 32'd1);

    // Good frame with the consumer always ready.
    send_frame(16'h1234, 16'hABCD, 1'b0, 0, 0, 0);
    check("good_m_valid", 32'(m_valid), 32'd1);
    check("good_m_a", 32'(m_a), 32'h1234);
    check("good_m_b", 32'(m_b), 32'hABCD);
    check("good_m_crc_ok", 32'(m_crc_ok), 32'd1);
    @(posedge clk);
    #1;
    check("good_m_valid_one_cycle", 32'(m_valid), 32'd0);
    check("good_s_ready_back", 32'(s_ready), 32'd1);

    // Same frame with a corrupted CRC beat.
    send_frame(16'h1234, 16'hABCD, 1'b1, 0, 0, 0);
    if (drop_bad) begin
      check("bad_dropped_m_valid", 32'(m_valid), 32'd0);
    end else begin
      check("bad_m_valid", 32'(m_valid), 32'd1);
      check("bad_m_crc_ok", 32'(m_crc_ok), 32'd0);
    end
    @(posedge clk);
    #1;

    // Backpressure: output held for 10 cycles, then released.
    ready_val = 1'b0;
    send_frame(16'h0F0F, 16'hF0F0, 1'b0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      check("bp_m_valid", 32'(m_valid), 32'd1);
      check("bp_m_a", 32'(m_a), 32'h0F0F);
      check("bp_m_b", 32'(m_b), 32'hF0F0);
      check("bp_s_ready", 32'(s_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    ready_val = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_s_ready", 32'(s_ready), 32'd1);
    check("bp_release_m_valid", 32'(m_valid), 32'd0);
    send_frame(16'h2468, 16'h1357, 1'b0, 0, 0, 0);
    @(posedge clk);
    #1;

    // Timeout after A: four idle edges abort the partial frame.
    send_beat(16'h5555, 0);
    abort_exp++;
    for (int i = 0; i < TO - 1; i++) begin
      @(posedge clk);
      #1;
      check("to_no_early_abort", 32'(abort), 32'd0);
    end
    @(posedge clk);
    #1;
    check("to_abort", 32'(abort), 32'd1);
    check("to_s_ready_idle", 32'(s_ready), 32'd1);
    check("to_m_valid", 32'(m_valid), 32'd0);
    @(posedge clk);
    #1;
    check("to_abort_one_cycle", 32'(abort), 32'd0);
    send_frame(16'h7777, 16'h8888, 1'b0, 0, 0, 0);
    check("to_next_m_a", 32'(m_a), 32'h7777);
    @(posedge clk);
    #1;

    // Timeout race: B and then CRC land on the edge the timeout would fire.
    send_frame(16'h3C3C, 16'hC3C3, 1'b0, 0, TO - 1, TO - 1);
    check("race_m_valid", 32'(m_valid), 32'd1);
    @(posedge clk);
    #1;

    // Saturation of the CRC error counter.
    for (int i = 0; i < 260; i++) begin
      send_frame(16'($urandom), 16'($urandom), 1'b1, 0, 0, 0);
    end
    check("sat_crc_err_cnt", 32'(crc_err_cnt), 32'd255);

    // Reset in the middle of a frame.
    send_beat(16'hDEAD, 0);
    rstn = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    err_model = 0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    send_frame(16'hBEEF, 16'hCAFE, 1'b0, 0, 0, 0);
    check("postreset_m_a", 32'(m_a), 32'hBEEF);
    check("postreset_m_b", 32'(m_b), 32'hCAFE);

    // Randomized frames, gaps below the timeout, random consumer ready.
    rnd_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      send_frame(ra, rb, ($urandom_range(0, 3) == 0), $urandom_range(0, TO - 1),
                 $urandom_range(0, TO - 1), $urandom_range(0, TO - 1));
    end
    rnd_ready = 1'b0;
    ready_val = 1'b1;
    drain = 0;
    while (exp_q.size() != 0 && drain < 20) begin
      @(posedge clk);
      #1;
      drain++;
    end
    check("drain_expected_frames", 32'(exp_q.size()), 32'd0);
    check("abort_count", 32'(abort_seen), 32'(abort_exp));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sm_frame_rx.md
# sm_frame_rx

Receive side of the three-beat push protocol: collects an A word, a B word and a CRC word from a valid/ready stream and checks the CRC over A then B. Each checked frame is presented on a single-entry output register with a pass/fail flag. The block also counts CRC failures and aborts a partial frame when the next beat does not arrive in time. It sits between the link input and the consumer of A/B pairs.

## Interface
- DATA_W, 16: width of every beat, of the CRC and of the CRC polynomial.
- CRC_POLY, 16'h1021: CRC polynomial, MSB-first, non-reflected.
- CRC_INIT, 16'hFFFF: CRC seed, loaded at the start of each frame.
- TIMEOUT, 255: maximum idle cycles allowed between beats inside a frame. 0 disables the timeout.
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- s_data  in  DATA_W  input beat
- s_valid  in  1  input beat valid
- s_ready  out  1  block accepts a beat (registered)
- m_a  out  DATA_W  received A word
- m_b  out  DATA_W  received B word
- m_crc_ok  out  1  1 = received CRC matched the computed CRC
- m_valid  out  1  output frame valid
- m_ready  in  1  consumer accepts the output frame
- abort  out  1  one-cycle pulse when a partial frame is dropped on timeout
- crc_err_cnt  out  8  count of CRC failures, saturates at 255

## Operation
- A beat is accepted on a rising edge where s_valid && s_ready.
- States and transitions:
  - IDLE: accepting A. On accept, store A, set crc = step(CRC_INIT, A), go to GOT_A.
  - GOT_A: accepting B. On accept, store B, set crc = step(crc, B), go to GOT_B.
  - GOT_B: accepting the CRC beat. On accept, set m_crc_ok = (s_data == crc) and go to OUT.
  - OUT: holds m_valid = 1. On m_valid && m_ready, go to IDLE.
- CRC step: one full DATA_W-bit update per cycle, MSB first, combinational. No final XOR.
- On a CRC mismatch, crc_err_cnt increments on the same edge the CRC beat is accepted. It saturates at 255.
- s_ready is 1 in IDLE, GOT_A and GOT_B, and 0 in OUT. It is registered from the next state.
- Timeout (TIMEOUT > 0):
  - In GOT_A and GOT_B, a counter increments on each cycle with no accept and clears on any accept.
  - When the counter reaches TIMEOUT: return to IDLE, discard the partial frame, pulse abort for 1 cycle. crc_err_cnt is unchanged.
- Simultaneous events:
  - A beat accepted in the same cycle the counter would reach TIMEOUT wins; no abort is raised.
  - A CRC mismatch while crc_err_cnt = 255 leaves the count at 255.
- Reset mid-frame: the partial frame is discarded and all outputs return to their reset values.

## Timing
- Reset values: s_ready = 0, m_valid = 0, m_a = 0, m_b = 0, m_crc_ok = 0, abort = 0, crc_err_cnt = 0, state = IDLE, timeout counter = 0.
- s_ready rises on the first clk edge after rstn deasserts.
- Latency: CRC beat accepted on edge N → m_valid = 1 after edge N. m_a, m_b and m_crc_ok are stable while m_valid = 1.
- Back-to-back beats are accepted at 1 beat/cycle within a frame.
- After the output handshake on edge M, s_ready = 1 after edge M. This gives one bubble cycle per frame.
- m_valid stays high indefinitely until m_ready. No beats are accepted while in OUT.
- abort is high for exactly the cycle after the edge on which the timeout fires.

## Configuration
- SM_FRAME_RX_DROP_BAD_EN:
  - Defined: a frame with a bad CRC is not presented. GOT_B goes directly to IDLE, m_valid stays 0, and crc_err_cnt still increments. m_crc_ok is then always 1 when m_valid = 1.
  - Undefined: every complete frame is presented, and bad frames carry m_crc_ok = 0.

## Test plan
- Good frame: A = 0x1234, B = 0xABCD, CRC beat from the reference model, m_ready = 1 → m_valid for 1 cycle, m_a = 0x1234, m_b = 0xABCD, m_crc_ok = 1, crc_err_cnt = 0.
- Bad CRC: same frame with the CRC XOR 0x0001:
  - Macro undefined → m_crc_ok = 0, crc_err_cnt = 1.
  - Macro defined → no m_valid, crc_err_cnt = 1.
- Backpressure: m_ready = 0 for 10 cycles after a good frame → m_valid and data held, s_ready = 0 throughout. Handshake → s_ready = 1 on the next cycle, and the next frame is received correctly.
- Timeout: TIMEOUT = 4, send A, then idle 4 cycles → abort pulses once, state IDLE. A following complete frame gives m_a equal to the new A.
- Timeout race: TIMEOUT = 4, B presented on exactly the 4th idle cycle → B accepted, no abort, frame completes.
- Saturation and reset: 260 bad frames → crc_err_cnt = 255. Then rstn asserted mid-frame after A → all outputs 0, and the next frame decodes correctly.
